// File: rtl/counter_access_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | counter_access_arbiter: shared count register, WB/LA round-robin access, |
// | compare-match IRQ. Optional prescaler: COUNTER_PRESCALER_EN. Rev 1.0     |
// +--------------------------------------------------------------------------+
module counter_access_arbiter #(
  parameter int BITS = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  input  logic            la_req_i,
  input  logic [BITS-1:0] la_data_i,
  output logic            la_gnt_o,
  output logic [BITS-1:0] count_o,
  output logic            irq_o
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACK = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [BITS-1:0] count_q, count_d, compare_q, compare_d;
  logic            run_q, run_d, irq_en_q, irq_en_d;
  logic            match_q, match_d, upd_q, upd_d, last_la_q, last_la_d;
  logic [31:0]     dat_q, dat_d;
`ifdef COUNTER_PRESCALER_EN
  logic [7:0]      prescale_q, prescale_d, pre_q, pre_d;
`endif

  logic        wb_valid, wb_gnt, la_gnt, wb_wr, wr_count, inc;
  logic [2:0]  ra;
  logic [31:0] rdata, wmask, wmerged;
  logic        unused_bits;

  assign ra       = wbs_adr_i[4:2];
  assign wb_valid = wbs_cyc_i & wbs_stb_i;
  // Contention in IDLE goes to whoever was not granted last; ACK leaves the register free for LA.
  assign wb_gnt   = (state_q == ST_IDLE) && wb_valid && (!la_req_i || last_la_q);
  assign la_gnt   = la_req_i && ((state_q == ST_ACK) || !wb_valid || !last_la_q);
  assign wb_wr    = wb_gnt & wbs_we_i;
  assign wr_count = wb_wr && (ra == 3'd0);
  assign wmask    = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign wmerged  = (wbs_dat_i & wmask) | (rdata & ~wmask);

`ifdef COUNTER_PRESCALER_EN
  assign inc = run_q && (pre_q == prescale_q);
`else
  assign inc = run_q;
`endif

  always_comb begin
    rdata = '0;
    case (ra)
      3'd0:    rdata = 32'(count_q);
      3'd1:    rdata = {30'd0, irq_en_q, run_q};
      3'd2:    rdata = 32'(compare_q);
      3'd3:    rdata = {31'd0, match_q};
`ifdef COUNTER_PRESCALER_EN
      3'd4:    rdata = {24'd0, prescale_q};
`endif
      default: rdata = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    compare_d = compare_q;
    run_d     = run_q;
    irq_en_d  = irq_en_q;
    match_d   = match_q;
    upd_d     = 1'b0;
    last_la_d = last_la_q;
    dat_d     = dat_q;
`ifdef COUNTER_PRESCALER_EN
    prescale_d = prescale_q;
    pre_d      = (pre_q == prescale_q) ? 8'd0 : pre_q + 8'd1;
    if (!run_q || wr_count || la_gnt) pre_d = 8'd0;
`endif

    case (state_q)
      ST_IDLE: if (wb_gnt) state_d = ST_ACK;
      default: state_d = ST_IDLE;
    endcase

    if (wb_gnt) last_la_d = 1'b0;
    else if (la_gnt) last_la_d = 1'b1;
    if (wb_gnt && !wbs_we_i) dat_d = rdata;

    if (wb_wr) begin
      case (ra)
        3'd1: begin
          run_d    = wmerged[0];
          irq_en_d = wmerged[1];
        end
        3'd2: compare_d = wmerged[BITS-1:0];
`ifdef COUNTER_PRESCALER_EN
        3'd4: prescale_d = wmerged[7:0];
`endif
        default: ;
      endcase
    end

    if (wr_count) begin
      count_d = wmerged[BITS-1:0];
      upd_d   = 1'b1;
    end else if (la_gnt) begin
      count_d = la_data_i;
      upd_d   = 1'b1;
    end else if (inc) begin
      count_d = count_q + BITS'(1);
      upd_d   = 1'b1;
    end

    // Match is judged one edge after the update so the clear and a fresh hit can coexist.
    if (wb_wr && (ra == 3'd3) && wbs_sel_i[0] && wbs_dat_i[0]) match_d = 1'b0;
    if (upd_q && (count_q == compare_q)) match_d = 1'b1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      compare_q <= '1;
      run_q     <= 1'b0;
      irq_en_q  <= 1'b0;
      match_q   <= 1'b0;
      upd_q     <= 1'b0;
      last_la_q <= 1'b1;
      dat_q     <= '0;
`ifdef COUNTER_PRESCALER_EN
      prescale_q <= 8'd0;
      pre_q      <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      run_q     <= run_d;
      irq_en_q  <= irq_en_d;
      match_q   <= match_d;
      upd_q     <= upd_d;
      last_la_q <= last_la_d;
      dat_q     <= dat_d;
`ifdef COUNTER_PRESCALER_EN
      prescale_q <= prescale_d;
      pre_q      <= pre_d;
`endif
    end
  end

  assign wbs_ack_o   = (state_q == ST_ACK);
  assign wbs_dat_o   = dat_q;
  assign la_gnt_o    = la_gnt & ~wb_rst_i;
  assign count_o     = count_q;
  assign irq_o       = match_q & irq_en_q;
  assign unused_bits = ^{wbs_adr_i[31:5], wbs_adr_i[1:0], wmerged};

endmodule
`default_nettype wire

// File: doc/counter_access_arbiter.md
Name: counter_access_arbiter

Overview:
Owns a shared BITS-wide count register and schedules every access to it from two requesters: the Wishbone slave (register reads/writes) and a Logic Analyzer load port. It runs a run/stop free-running increment and applies round-robin arbitration when both requesters contend. It also raises a compare-match IRQ. It sits in the user project between the Wishbone MI A bus, LA probes and the GPIO count output.

Parameters:
BITS, 16, width of count and compare registers (1..32)

Ports:
wb_clk_i  input  1  single clock for all logic
wb_rst_i  input  1  synchronous active-high reset
wbs_stb_i  input  1  Wishbone strobe
wbs_cyc_i  input  1  Wishbone cycle
wbs_we_i  input  1  Wishbone write enable
wbs_sel_i  input  4  Wishbone byte selects
wbs_adr_i  input  32  Wishbone address; only [4:2] decoded
wbs_dat_i  input  32  Wishbone write data
wbs_ack_o  output  1  Wishbone acknowledge
wbs_dat_o  output  32  Wishbone read data
la_req_i  input  1  LA load request (level)
la_data_i  input  BITS  LA load value
la_gnt_o  output  1  one-cycle pulse on the edge where the LA load is applied
count_o  output  BITS  current count (to io_out)
irq_o  output  1  match interrupt

Behaviour:
- Register map (adr[4:2]): 0 COUNT R/W; 1 CTRL R/W (bit0 run, bit1 irq_en); 2 COMPARE R/W; 3 STATUS (bit0 match, sticky, write-1-to-clear); 4 PRESCALE (see Optional Feature); 5-7 read 0, writes ignored. Read bits above BITS return 0.
- Writes honour wbs_sel_i per byte. Bits above BITS are dropped.
- Reset: count=0, CTRL=0, COMPARE={BITS{1}}, match=0, wbs_ack_o=0, wbs_dat_o=0, la_gnt_o=0, FSM=IDLE, last_grant=LA.
- FSM states: IDLE, ACK.
  - IDLE: valid = cyc&stb. A granted WB request performs its access on that edge; the FSM goes to ACK and wbs_dat_o latches the read data.
  - ACK: wbs_ack_o=1 for exactly one cycle, then IDLE. Next request is accepted no earlier than the cycle after ACK.
  - WB latency: request sampled at edge N, ack high in cycle N+1.
- Arbitration:
  - Only IDLE arbitrates. If WB and la_req_i are both pending, the requester that was not last_grant wins; last_grant updates on every grant.
  - A losing WB request waits in IDLE; a losing LA request holds la_req_i.
  - In ACK the bus is not using the resource, so LA is granted unconditionally if requesting.
- Count update priority per edge: WB write to COUNT > LA load > increment (run=1) > hold.
- Increment wraps {BITS{1}} -> 0 without a flag.
- Match: after an update, if new count == COMPARE, set match. Loads/writes also trigger it. A W1C and a new match on the same edge leave match=1.
- irq_o = match & irq_en, registered-free combinational from flops.
- Reset asserted mid-transaction: FSM returns to IDLE, no ack issued; the master must reissue.

Optional Feature:
Macro COUNTER_PRESCALER_EN.
- Defined: adds an 8-bit PRESCALE register at adr 4 (reset 0) and an internal prescale counter. Increment occurs only when the prescale counter equals PRESCALE; the prescale counter then clears, and it also clears on any COUNT write/LA load and when run=0.
- Undefined: increment every cycle while run=1; adr 4 reads 0, writes ignored, no prescale flops.

Test Plan:
- Reset, read COUNT, CTRL, COMPARE -> 0x0, 0x0, 0xFFFF; ack exactly one cycle after request each time.
- Write CTRL=1, wait 10 cycles, read COUNT -> value increases by 1 per cycle; preload 0xFFFE via LA, run -> sequence FFFE, FFFF, 0000.
- Same cycle WB write COUNT=0x1234 and la_req_i with 0x00AA -> WB granted first (last_grant=LA); la_gnt_o pulses during ACK cycle; final count 0x00AA (+run increments if enabled).
- Back-to-back contention twice -> grants alternate WB, LA, WB, LA.
- COMPARE=0x0005, CTRL=3, count from 0 -> irq_o rises the cycle after count becomes 5; write STATUS=1 -> irq_o low; wbs_sel_i=4'b0010 write 0xAB00 to COUNT -> only bits [15:8] change.
- With COUNTER_PRESCALER_EN, PRESCALE=3, run -> count increments every 4 cycles; assert wb_rst_i during ACK -> wbs_ack_o low next cycle, all registers at reset values.
